// File: rtl/mont_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mont_pkg
// Description : Shared types and Kyber constants for the Montgomery multiplier
//               pipeline: operation mode encoding, default field widths, and
//               the per-stage sideband record carried alongside the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package mont_pkg;

    // Kyber defaults: q = 3329, R = 2^12
    localparam int KYBER_WIDTH   = 12;
    localparam int KYBER_MOD     = 3329;
    localparam int KYBER_MOD_INV = 3327;   // -q^-1 mod R
    localparam int KYBER_R2_MOD  = 2385;   // R^2 mod q
    localparam int KYBER_TAG_W   = 4;

    typedef enum logic [1:0] {
        MODE_MONT      = 2'd0,   // a*b*R^-1
        MODE_TO_MONT   = 2'd1,   // a*R
        MODE_MODMUL    = 2'd2,   // a*b
        MODE_FROM_MONT = 2'd3    // a*R^-1
    } mode_e;

    // Sideband travelling with each pipeline slot. The field widths follow
    // the package defaults; the top is instantiated with matching widths.
    typedef struct packed {
        logic                   valid;
        mode_e                  mode;
        logic [KYBER_TAG_W-1:0] tag;
        logic [KYBER_WIDTH-1:0] data;   // pass-A result, used from pass B on
    } stage_t;

endpackage
`default_nettype wire

// File: rtl/redc_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : redc_stage
// Description : Three-register Montgomery reduction core computing
//               x*y*2^-WIDTH mod MOD. Registers: product, m, final result.
//               All registers advance together on i_en.
// Ports       : clk, rst (async, active-high)
//               i_en  - advance enable (low = hold)
//               i_x   - operand x
//               i_y   - operand y
//               o_r   - reduced result (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module redc_stage #(
    parameter int WIDTH   = 12,
    parameter int MOD     = 3329,
    parameter int MOD_INV = 3327
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    output logic [WIDTH-1:0] o_r
);

    localparam logic [WIDTH-1:0] c_mod     = WIDTH'(MOD);
    localparam logic [WIDTH-1:0] c_mod_inv = WIDTH'(MOD_INV);

    logic [2*WIDTH-1:0] r_t;       // stage 1: T = x*y
    logic [2*WIDTH-1:0] r_t_d;     // stage 2: T carried forward
    logic [WIDTH-1:0]   r_m;       // stage 2: m
    logic [WIDTH-1:0]   r_res;     // stage 3: final result

    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_m;
    logic [2*WIDTH-1:0] w_mq;
    logic [2*WIDTH:0]   w_sum;
    logic [WIDTH:0]     w_u;
    logic [WIDTH:0]     w_red;
    logic               w_unused;

    assign w_prod = {{WIDTH{1'b0}}, i_x} * {{WIDTH{1'b0}}, i_y};
    // Truncating WIDTH x WIDTH product gives m = T_lo*MOD_INV mod 2^WIDTH
    assign w_m    = r_t[WIDTH-1:0] * c_mod_inv;
    assign w_mq   = {{WIDTH{1'b0}}, r_m} * {{WIDTH{1'b0}}, c_mod};
    assign w_sum  = {1'b0, r_t_d} + {1'b0, w_mq};
    assign w_u    = w_sum[2*WIDTH:WIDTH];
    assign w_red  = (w_u >= {1'b0, c_mod}) ? (w_u - {1'b0, c_mod}) : w_u;

    // Low half of the sum is zero by construction and the top bit of the
    // corrected value is clear for in-range operands.
    assign w_unused = ^{w_sum[WIDTH-1:0], w_red[WIDTH]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_t   <= '0;
            r_t_d <= '0;
            r_m   <= '0;
            r_res <= '0;
        end else if (i_en) begin
            r_t   <= w_prod;
            r_t_d <= r_t;
            r_m   <= w_m;
            r_res <= w_red[WIDTH-1:0];
        end
    end

    assign o_r = r_res;

endmodule
`default_nettype wire

// File: rtl/mont_mul_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mont_mul_pipe
// Description : Six-stage pipelined Montgomery modular multiplier with
//               valid/ready flow control, four operation modes and a tag
//               carried with every result. Pass A (stages 1-3) and pass B
//               (stages 4-6) are REDC cores; pass B is only used by MODMUL,
//               all other modes take the delayed pass-A result.
// Ports       : clk, rst (async, active-high)
//               in_valid/in_ready   - input handshake
//               in_mode             - 0 MONT, 1 TO_MONT, 2 MODMUL, 3 FROM_MONT
//               in_a, in_b, in_tag  - operands and user tag
//               out_valid/out_ready - output handshake
//               out_r, out_tag      - result in [0, MOD) and its tag
// Revision    : 1.0 - initial release
// ============================================================================
module mont_mul_pipe
    import mont_pkg::*;
#(
    parameter int WIDTH   = KYBER_WIDTH,
    parameter int MOD     = KYBER_MOD,
    parameter int MOD_INV = KYBER_MOD_INV,
    parameter int R2_MOD  = KYBER_R2_MOD,
    parameter int TAG_W   = KYBER_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_r,
    output logic [TAG_W-1:0] out_tag
);

    localparam int               c_depth   = 6;
    localparam int               c_pass_b  = 4;   // first stage of pass B
    localparam logic [WIDTH-1:0] c_r2      = WIDTH'(R2_MOD);
    localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);

    logic             w_en;
    logic [WIDTH-1:0] w_a_y;
    logic [WIDTH-1:0] w_pass_a;
    logic [WIDTH-1:0] w_pass_b;
    stage_t           w_nxt [1:c_depth];
    stage_t           r_stg [1:c_depth];

    // The whole pipe holds only when a result is waiting and not taken;
    // bubbles never hold it.
    assign w_en     = !r_stg[c_depth].valid || out_ready;
    assign in_ready = !rst && w_en;

    // Pass-A second operand by mode
    always_comb begin
        w_a_y = in_b;
        case (mode_e'(in_mode))
            MODE_TO_MONT:   w_a_y = c_r2;
            MODE_FROM_MONT: w_a_y = c_one;
            default:        w_a_y = in_b;
        endcase
    end

    redc_stage #(
        .WIDTH   (WIDTH),
        .MOD     (MOD),
        .MOD_INV (MOD_INV)
    ) u_redc_a (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_en),
        .i_x  (in_a),
        .i_y  (w_a_y),
        .o_r  (w_pass_a)
    );

    redc_stage #(
        .WIDTH   (WIDTH),
        .MOD     (MOD),
        .MOD_INV (MOD_INV)
    ) u_redc_b (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_en),
        .i_x  (w_pass_a),
        .i_y  (c_r2),
        .o_r  (w_pass_b)
    );

    // Sideband shift: stage 1 loads the input slot (a bubble when in_valid
    // is low); pass B's first stage also captures pass A's result so that
    // non-MODMUL modes can bypass the second reduction.
    always_comb begin
        w_nxt[1] = '{valid: in_valid, mode: mode_e'(in_mode), tag: in_tag,
                     data: '0};
        for (int k = 2; k <= c_depth; k++) begin
            w_nxt[k] = r_stg[k-1];
        end
        w_nxt[c_pass_b].data = w_pass_a;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= c_depth; k++) begin
                r_stg[k] <= '0;
            end
        end else if (w_en) begin
            for (int k = 1; k <= c_depth; k++) begin
                r_stg[k] <= w_nxt[k];
            end
        end
    end

    // Reset leaves mode = MONT and data = 0, so out_r reads 0 from the bypass
    assign out_valid = r_stg[c_depth].valid;
    assign out_tag   = r_stg[c_depth].tag;
    assign out_r     = (r_stg[c_depth].mode == MODE_MODMUL) ? w_pass_b
                                                             : r_stg[c_depth].data;

endmodule
`default_nettype wire

// File: tb/tb_mont_mul_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mont_mul_pipe
// Description : Self-checking bench for mont_mul_pipe: directed vectors with
//               hand-computed results plus a scoreboard fed by a plain
//               modular-arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mont_mul_pipe;

    localparam longint c_q    = 3329;
    localparam longint c_r    = 4096;
    localparam longint c_rinv = 2704;   // 4096^-1 mod 3329

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_mode = 2'd0;
    logic [11:0] in_a = '0;
    logic [11:0] in_b = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] out_r;
    logic [3:0]  out_tag;

    mont_mul_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ref_model(input logic [1:0] m,
                                              input logic [11:0] a,
                                              input logic [11:0] b);
        longint la = longint'(a);
        longint lb = longint'(b);
        longint r;
        case (m)
            2'd0:    r = ((la * lb) % c_q) * c_rinv % c_q;
            2'd1:    r = (la * c_r) % c_q;
            2'd2:    r = (la * lb) % c_q;
            default: r = (la * c_rinv) % c_q;
        endcase
        return 12'(r);
    endfunction

    typedef struct {
        logic [3:0]  tag;
        logic [11:0] r;
    } exp_t;

    exp_t sb[$];
    int   n_out   = 0;
    int   run_len = 0;
    int   max_run = 0;

    // Scoreboard: inputs are stable over the negedge before the edge that
    // takes them, and outputs are stable away from the posedge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_out++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
                check_eq("out_range", {31'b0, (out_r < 12'd3329)}, 32'd1);
                if (sb.size() == 0) begin
                    check_eq("unexpected_out", {31'b0, out_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("sb_r", {20'b0, out_r}, {20'b0, e.r});
                    check_eq("sb_tag", {28'b0, out_tag}, {28'b0, e.tag});
                end
            end else begin
                run_len = 0;
            end
            if (in_valid && in_ready) begin
                sb.push_back('{tag: in_tag, r: ref_model(in_mode, in_a, in_b)});
            end
        end
    end

    task automatic run_one(input string name, input logic [1:0] m,
                           input logic [11:0] a, input logic [11:0] b,
                           input logic [3:0] t, input logic [11:0] exp);
        int lat;
        @(posedge clk); #1;
        in_valid = 1'b1; in_mode = m; in_a = a; in_b = b; in_tag = t;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({name, "_lat"}, lat, 32'd6);
        check_eq({name, "_r"}, {20'b0, out_r}, {20'b0, exp});
        check_eq({name, "_tag"}, {28'b0, out_tag}, {28'b0, t});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Directed edge vectors: mode, a, b, expected
    logic [1:0]  e_mode [10] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd0, 2'd2, 2'd1, 2'd3, 2'd0};
    logic [11:0] e_a    [10] = '{12'd1, 12'd767, 12'd767, 12'd3328, 12'd3328,
                                 12'd0, 12'd2000, 12'd0, 12'd0, 12'd3328};
    logic [11:0] e_b    [10] = '{12'd3000, 12'd55, 12'd767, 12'd3328, 12'd1,
                                 12'd1234, 12'd0, 12'd9, 12'd17, 12'd0};
    logic [11:0] e_exp  [10] = '{12'd767, 12'd1, 12'd767, 12'd1, 12'd625,
                                 12'd0, 12'd0, 12'd0, 12'd0, 12'd0};

    initial begin
        int base;
        int n;

        // Reset state
        #12;
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check_eq("rst_out_r", {20'b0, out_r}, 32'd0);
        check_eq("rst_out_tag", {28'b0, out_tag}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // First op: MODMUL 17*200 mod q = 71, latency 6
        run_one("modmul_17_200", 2'd2, 12'd17, 12'd200, 4'd5, 12'd71);

        for (int i = 0; i < 10; i++) begin
            run_one($sformatf("edge%0d", i), e_mode[i], e_a[i], e_b[i],
                    4'(i), e_exp[i]);
        end
        idle(3);

        // Back-to-back mixed modes at full rate
        max_run = 0;
        base = n_out;
        for (int i = 0; i < 200; i++) begin
            in_valid = 1'b1;
            in_mode  = 2'($urandom_range(0, 3));
            in_a     = 12'($urandom_range(0, 3328));
            in_b     = 12'($urandom_range(0, 3328));
            in_tag   = 4'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n = 0;
        while ((n_out - base) < 200 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        idle(2);
        check_eq("burst_count", n_out - base, 32'd200);
        check_eq("burst_run", max_run, 32'd200);

        // Backpressure with six ops in flight
        out_ready = 1'b0;
        base = n_out;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_mode  = (k == 0) ? 2'd2 : 2'(k % 4);
            in_a     = (k == 0) ? 12'd17 : 12'(100 * k + 3);
            in_b     = (k == 0) ? 12'd200 : 12'(250 * k + 11);
            in_tag   = 4'(k + 8);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_eq("stall_head_valid", {31'b0, out_valid}, 32'd1);
        for (int s = 0; s < 4; s++) begin
            check_eq("stall_r", {20'b0, out_r}, 32'd71);
            check_eq("stall_tag", {28'b0, out_tag}, 32'd8);
            check_eq("stall_in_ready", {31'b0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        check_eq("stall_no_drain", n_out - base, 32'd0);
        out_ready = 1'b1;
        n = 0;
        while ((n_out - base) < 6 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        idle(4);
        check_eq("stall_release_count", n_out - base, 32'd6);

        // Reset with three ops in flight, head one waiting at the output
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_mode  = 2'd0;
            in_a     = 12'd767;
            in_b     = 12'd767;
            in_tag   = 4'(k + 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("async_rst_in_ready", {31'b0, in_ready}, 32'd0);
        sb.delete();
        idle(2);
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        base = n_out;
        idle(12);
        check_eq("no_stale_out", n_out - base, 32'd0);
        run_one("post_rst_mont", 2'd0, 12'd767, 12'd767, 4'd6, 12'd767);
        idle(3);
        check_eq("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
`default_nettype wire
